// File: rtl/fc_argmax.sv
// Output-layer sequencer: steps the shared FC neuron through every class, tracks
// the running signed maximum and reports the winning class or a reject code.
module fc_argmax #(
  parameter int N_CLASS = 5,
  parameter int CLS_W   = 3,
  parameter int TIMEOUT = 15
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [31:0]        i_thresh,
  input  logic [31:0]        i_fc_output,
  input  logic               i_fc_finished,
  output logic               o_fc_start,
  output logic [CLS_W-1:0]   o_class_sel,
  output logic               o_busy,
  output logic               o_valid,
  output logic [CLS_W-1:0]   o_class,
  output logic [31:0]        o_score,
  output logic               o_error
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [CLS_W-1:0] LAST_K = CLS_W'(N_CLASS - 1);
  localparam logic [CLS_W-1:0] REJECT = CLS_W'(N_CLASS);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t             state_reg, state_next;
  logic [CLS_W-1:0]   k_reg, k_next;
  logic [CLS_W-1:0]   argmax_reg, argmax_next;
  logic [31:0]        max_reg, max_next;
  logic [31:0]        thresh_reg, thresh_next;
  logic [TMR_W-1:0]   timer_reg, timer_next;
  logic               err_reg, err_next;

  logic               fc_start_reg, fc_start_next;
  logic [CLS_W-1:0]   class_sel_reg, class_sel_next;
  logic               busy_reg, busy_next;
  logic               valid_reg, valid_next;
  logic [CLS_W-1:0]   class_reg, class_next;
  logic [31:0]        score_reg, score_next;
  logic               error_reg, error_next;

  // State and datapath register; the reset is synchronous and active-high.
  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      state_reg     <= S_IDLE;
      k_reg         <= '0;
      argmax_reg    <= '0;
      max_reg       <= '0;
      thresh_reg    <= '0;
      timer_reg     <= '0;
      err_reg       <= 1'b0;
      fc_start_reg  <= 1'b0;
      class_sel_reg <= '0;
      busy_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      class_reg     <= '0;
      score_reg     <= '0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      k_reg         <= k_next;
      argmax_reg    <= argmax_next;
      max_reg       <= max_next;
      thresh_reg    <= thresh_next;
      timer_reg     <= timer_next;
      err_reg       <= err_next;
      fc_start_reg  <= fc_start_next;
      class_sel_reg <= class_sel_next;
      busy_reg      <= busy_next;
      valid_reg     <= valid_next;
      class_reg     <= class_next;
      score_reg     <= score_next;
      error_reg     <= error_next;
    end
  end

  // Next-state and running-max update.
  always_comb begin
    state_next  = state_reg;
    k_next      = k_reg;
    argmax_next = argmax_reg;
    max_next    = max_reg;
    thresh_next = thresh_reg;
    timer_next  = timer_reg;
    err_next    = err_reg;
    case (state_reg)
      S_IDLE: begin
        if (i_start) begin
          state_next  = S_START;
          thresh_next = i_thresh;
          k_next      = '0;
          err_next    = 1'b0;
        end
      end
      S_START: begin
        state_next = S_WAIT;
        timer_next = '0;
      end
      S_WAIT: begin
        if (i_fc_finished) begin
          // Strict greater-than keeps the lower index on ties.
          if (k_reg == '0 || $signed(i_fc_output) > $signed(max_reg)) begin
            max_next    = i_fc_output;
            argmax_next = k_reg;
          end
          if (k_reg == LAST_K) begin
            state_next = S_DONE;
          end else begin
            k_next     = k_reg + CLS_W'(1);
            state_next = S_START;
          end
        end else if (timer_reg == TMR_LAST) begin
          state_next = S_DONE;
          err_next   = 1'b1;
        end else begin
          timer_next = timer_reg + TMR_W'(1);
        end
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they appear registered.
  always_comb begin
    fc_start_next  = (state_next == S_START);
    class_sel_next = (state_next == S_IDLE) ? '0 : k_next;
    busy_next      = (state_next == S_START) || (state_next == S_WAIT);
    valid_next     = (state_next == S_DONE);
    class_next     = class_reg;
    score_next     = score_reg;
    error_next     = error_reg;
    if (state_next == S_DONE) begin
      error_next = err_next;
      score_next = err_next ? '0 : max_next;
      class_next = (err_next || $signed(max_next) < $signed(thresh_reg)) ? REJECT : argmax_next;
    end
  end

  assign o_fc_start  = fc_start_reg;
  assign o_class_sel = class_sel_reg;
  assign o_busy      = busy_reg;
  assign o_valid     = valid_reg;
  assign o_class     = class_reg;
  assign o_score     = score_reg;
  assign o_error     = error_reg;

endmodule

// File: tb/tb_fc_argmax.sv
// Scoreboard bench for fc_argmax: an FC neuron model answers each start pulse and
// a monitor compares every result pulse against the expected queue.
module tb_fc_argmax;
  localparam int N  = 5;
  localparam int CW = 3;
  localparam int TO = 15;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b1;
  logic          i_start = 1'b0;
  logic [31:0]   i_thresh = '0;
  logic [31:0]   i_fc_output = '0;
  logic          i_fc_finished = 1'b0;
  logic          o_fc_start;
  logic [CW-1:0] o_class_sel;
  logic          o_busy;
  logic          o_valid;
  logic [CW-1:0] o_class;
  logic [31:0]   o_score;
  logic          o_error;

  fc_argmax #(.N_CLASS(N), .CLS_W(CW), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_thresh(i_thresh),
    .i_fc_output(i_fc_output), .i_fc_finished(i_fc_finished),
    .o_fc_start(o_fc_start), .o_class_sel(o_class_sel), .o_busy(o_busy),
    .o_valid(o_valid), .o_class(o_class), .o_score(o_score), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [CW-1:0] cls;
    logic [31:0]   score;
    logic          err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   valid_seen = 0;
  int   valid_cyc = 0;
  int   n_starts = 0;
  int   start_idx = 0;

  // FC neuron model configuration
  int   sc[N];
  int   lat = 2;
  int   drop = N;
  bit   stray = 0;
  int   cnt = 0;
  int   cls_pend = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, $signed(act), $signed(expv), cyc);
    end
  endtask

  // FC neuron: answers a start after lat cycles; class 'drop' never answers.
  always @(negedge i_clk) begin
    i_fc_finished = 1'b0;
    i_fc_output   = 32'h1234_5678;
    if (i_rst_n) begin
      cnt = 0;
    end else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          i_fc_finished = 1'b1;
          i_fc_output   = sc[cls_pend];
        end
      end
      if (o_fc_start) begin
        if (stray) begin
          i_fc_finished = 1'b1;
          i_fc_output   = 32'h7fff_ffff;
        end
        if (int'(o_class_sel) != drop) begin
          cnt      = lat;
          cls_pend = int'(o_class_sel);
        end
      end
    end
  end

  // Monitor: checks class select per start pulse and pops results on o_valid.
  always @(negedge i_clk) begin
    if (o_fc_start) begin
      chk("class_sel", 32'(o_class_sel), 32'(start_idx));
      start_idx++;
      n_starts++;
    end
    if (o_valid) begin
      exp_t e;
      valid_seen++;
      valid_cyc = cyc;
      start_idx = 0;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("class", 32'(o_class), 32'(e.cls));
        chk("score", o_score, e.score);
        chk("error", 32'(o_error), 32'(e.err));
        chk("busy_at_valid", 32'(o_busy), 32'd0);
        $display("result: class=%0d score=%0d error=%0b at cycle %0d", o_class, $signed(o_score), o_error, cyc);
      end
    end
  end

  // Reference: argmax with lowest index on ties, reject below threshold or on abort.
  function automatic exp_t model(input int thr, input int l, input int d);
    exp_t e;
    int best, bi;
    best = sc[0];
    bi = 0;
    for (int k = 1; k < N; k++) if (sc[k] > best) begin best = sc[k]; bi = k; end
    if (d < N || l > TO) begin
      e.cls = CW'(N); e.score = 0; e.err = 1'b1;
    end else begin
      e.cls = (best < thr) ? CW'(N) : CW'(bi);
      e.score = best;
      e.err = 1'b0;
    end
    return e;
  endfunction

  task automatic run(input int thr, input int l, input int d, input bit st, input bit hold_start);
    exp_t e;
    int c0, s0, v0, exp_starts;
    bit done;
    e = model(thr, l, d);
    exp_q.push_back(e);
    lat = l; drop = d; stray = st;
    @(negedge i_clk);
    i_start = 1'b1; i_thresh = thr;
    c0 = cyc; s0 = n_starts; v0 = valid_seen;
    @(negedge i_clk);
    i_start = hold_start;
    i_thresh = ~thr;
    done = 0;
    for (int t = 0; t < 400 && !done; t++) begin
      @(posedge i_clk);
      if (t == 8) i_start = 1'b0;
      done = (valid_seen != v0);
    end
    i_start = 1'b0;
    if (!done) chk("valid_timeout", 32'd0, 32'd1);
    if (done && !e.err) chk("valid_latency", 32'(valid_cyc - c0), 32'(1 + N * (l + 1)));
    exp_starts = e.err ? ((l > TO) ? 1 : d + 1) : N;
    chk("start_pulses", 32'(n_starts - s0), 32'(exp_starts));
    repeat (20) @(negedge i_clk);
    chk("class_hold", 32'(o_class), 32'(e.cls));
    stray = 0;
  endtask

  task automatic set_sc(input int a, input int b, input int c, input int d, input int f);
    sc[0] = a; sc[1] = b; sc[2] = c; sc[3] = d; sc[4] = f;
  endtask

  initial begin
    int c0;
    repeat (3) @(negedge i_clk);
    chk("rst_fc_start", 32'(o_fc_start), 32'd0);
    chk("rst_class_sel", 32'(o_class_sel), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_class", 32'(o_class), 32'd0);
    chk("rst_score", o_score, 32'd0);
    chk("rst_error", 32'(o_error), 32'd0);
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);

    set_sc(10, -5, 300, 299, 7);        run(0, 2, N, 0, 0);
    set_sc(-100, -3, -50, -8, -9);      run(-200, 2, N, 0, 0);
    run(0, 2, N, 0, 0);
    set_sc(50, 80, 80, 10, 80);         run(0, 2, N, 0, 0);
    set_sc(1, 2, 3, 4, 5);              run(0, 2, 2, 0, 0);
    run(0, 2, N, 0, 0);
    set_sc(9, 40, -7, 3, 39);           run(0, 2, N, 1, 1);
    run(-5, TO, N, 0, 0);
    run(-5, TO + 1, N, 0, 0);

    // Reset in cycle 7 of an inference discards it.
    set_sc(4, 5, 6, 7, 8);
    lat = 2; drop = N;
    @(negedge i_clk);
    i_start = 1'b1; i_thresh = 0; c0 = cyc;
    @(negedge i_clk);
    i_start = 1'b0;
    while (cyc < c0 + 7) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("mid_rst_fc_start", 32'(o_fc_start), 32'd0);
    chk("mid_rst_class_sel", 32'(o_class_sel), 32'd0);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_class", 32'(o_class), 32'd0);
    chk("mid_rst_score", o_score, 32'd0);
    i_rst_n = 1'b0;
    start_idx = 0;
    repeat (30) @(negedge i_clk);
    run(0, 2, N, 0, 0);

    for (int it = 0; it < 25; it++) begin
      int thr, l, d;
      for (int k = 0; k < N; k++)
        sc[k] = (it % 3 == 0) ? int'($urandom_range(0, 3)) - 1 : int'($urandom);
      thr = (it % 2 == 0) ? int'($urandom) : int'($urandom_range(0, 4)) - 2;
      l = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 1, TO + 2)) : int'($urandom_range(1, 5));
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, N - 1)) : N;
      run(thr, l, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fc_argmax.md
# fc_argmax

Output-layer sequencer and classifier placed directly downstream of the fully connected neuron (`FC`) block. Per inference it steps the shared FC neuron through `N_CLASS` output classes, one class at a time. For each class it selects the weight/bias set, pulses the neuron's start, captures its signed 32-bit score, and keeps a running maximum. After the last class it emits the winning class index, or a reject code if the best score is below a runtime threshold.

## Interface
Parameters:
- `N_CLASS`, 5: number of output classes evaluated per inference (≥2).
- `CLS_W`, 3: width of class index; must hold values 0..`N_CLASS`.
- `TIMEOUT`, 15: max cycles spent in `S_WAIT` for one class before aborting.

Ports:
- `i_clk` in, 1: the single clock.
- `i_rst_n` in, 1: reset, synchronous and **active-high** despite the name.
- `i_start` in, 1: request one inference; features already stable at FC input.
- `i_thresh` in, 32: signed reject threshold, sampled on accepted `i_start`.
- `i_fc_output` in, 32: signed FC score.
- `i_fc_finished` in, 1: FC one-cycle done pulse; score valid in the same cycle.
- `o_fc_start` out, 1: one-cycle start pulse to FC.
- `o_class_sel` out, `CLS_W`: class currently evaluated; drives the weight/bias mux.
- `o_busy` out, 1: inference in progress; upstream must hold features stable.
- `o_valid` out, 1: one-cycle result pulse.
- `o_class` out, `CLS_W`: argmax index, or `N_CLASS` = reject/no gesture.
- `o_score` out, 32: signed maximum score.
- `o_error` out, 1: set with `o_valid` when a timeout aborted the inference.

## Operation
States:
- `S_IDLE`: waits for `i_start`.
- `S_START`: drives `o_fc_start`.
- `S_WAIT`: waits for `i_fc_finished`, running the timeout counter.
- `S_DONE`: drives `o_valid`.

Transitions:
- `S_IDLE` → `S_START` when `i_start`. On this transition: latch `i_thresh`, set class counter k=0, set `o_busy`=1.
- `S_START` → `S_WAIT` unconditionally. `o_fc_start`=1 only while in `S_START`. Clear the timeout counter.
- `S_WAIT`, on `i_fc_finished`: capture `i_fc_output`.
  - If k==0, or the score is strictly greater (signed) than the running max: max←score, argmax←k. Ties keep the lower index.
  - If k==`N_CLASS`-1, go to `S_DONE`; else k←k+1 and go to `S_START`.
- `S_WAIT` timeout: after `TIMEOUT` consecutive cycles without `i_fc_finished`, go to `S_DONE` with error flag set.
- `S_DONE` → `S_IDLE`.
  - Outputs: `o_valid`=1 for one cycle; `o_busy` deasserts in the same cycle.
  - `o_score`=max; `o_class`=argmax, except `N_CLASS` if max < latched threshold (signed) or on error.
  - `o_error`=error flag; `o_score`=0 on error.

Rules:
- `o_class_sel`=k, held constant from `S_START` through the capturing cycle; 0 in `S_IDLE`.
- `i_start` while busy is ignored (no queueing).
- `i_fc_finished` outside `S_WAIT` is ignored.
- `o_class`, `o_score`, `o_error` hold their values until the next `o_valid`.
- All compares are signed 32-bit; no saturation.

## Timing
- Reset values: `o_fc_start`=0, `o_class_sel`=0, `o_busy`=0, `o_valid`=0, `o_class`=0, `o_score`=0, `o_error`=0; state `S_IDLE`.
- All outputs are registered.
- With the FC neuron (finished 2 cycles after start), `i_start` high in cycle 0 gives:
  - `o_fc_start` in cycles 1, 4, …, 3N−2.
  - Captures in cycles 3, 6, …, 3N.
  - `o_valid` in cycle 3N+1 (cycle 16 for N=5).
- Next `i_start` is accepted in cycle 3N+2 at the earliest (`S_IDLE`).
- Arbitrary FC latency up to `TIMEOUT` is tolerated.
- Reset mid-inference: next cycle all outputs are at reset values, no `o_valid` is produced, and the inference is discarded.

## Test plan
- Scores for classes 0..4 = {10, −5, 300, 299, 7}, thresh=0 → `o_valid` at cycle 16, `o_class`=2, `o_score`=300, `o_error`=0; `o_class_sel` steps 0..4 aligned with `o_fc_start`.
- All scores negative {−100, −3, −50, −8, −9}, thresh=−200 → `o_class`=1, `o_score`=−3 (signed compare). Same scores with thresh=0 → `o_class`=5 (reject), `o_score`=−3.
- Tie: {50, 80, 80, 10, 80} → `o_class`=1.
- FC model never pulses finished for class 2 → abort after 15 wait cycles: `o_valid`=1, `o_error`=1, `o_class`=5, `o_score`=0, `o_busy` drops; a following clean inference succeeds with `o_error`=0.
- `i_start` re-asserted during busy plus stray `i_fc_finished` in `S_START` → both ignored; exactly 5 `o_fc_start` pulses and one `o_valid`.
- `i_rst_n` asserted in cycle 7 → outputs at reset values from cycle 8, no `o_valid`; `i_start` afterwards gives a normal result 16 cycles later.
